// File: rtl/hgcal_input_packer.sv
// hgcal_input_packer
//
// Front end of the HGCAL autoencoder, directly ahead of the layer-0 LUT
// neurons. Raw cell charge samples arrive one per beat; each is quantized
// to IN_BITS by a right shift of Q_SHIFT followed by saturation. One frame
// of NUM_CELLS codes is collected and presented as a flat vector, cell i at
// bits [i*IN_BITS +: IN_BITS].
//
// Two frame slots: a fill register that collects codes, and an output
// register that drives m_data. A completed frame goes straight to the
// output register when it is empty or being handed off on the same edge.
// Otherwise it waits in the fill register and s_ready is held low.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   s_valid    input sample valid
//   s_ready    packer can accept a sample
//   s_data     raw unsigned sample (SAMPLE_W bits)
//   s_last     final sample of a frame
//   m_valid    packed frame valid
//   m_ready    consumer accepts the frame
//   m_data     packed codes (NUM_CELLS*IN_BITS bits)
//   err_short  one-cycle pulse: frame ended early and was dropped
//   err_long   one-cycle pulse: frame overran NUM_CELLS
//   err_cnt    (HGCAL_PACK_ERRCNT_EN only) saturating count of error pulses
//
// Build option
//   HGCAL_PACK_ERRCNT_EN  adds the err_cnt output and its counter.
//
// States
//   state   | meaning
//   FILL    | collecting codes into the fill register
//   DISCARD | overrun frame; swallow samples up to and including s_last

module hgcal_input_packer #(
  parameter int NUM_CELLS = 48,
  parameter int SAMPLE_W  = 16,
  parameter int IN_BITS   = 2,
  parameter int Q_SHIFT   = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [SAMPLE_W-1:0]            s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_CELLS*IN_BITS-1:0]   m_data,
  output logic                           err_short,
`ifdef HGCAL_PACK_ERRCNT_EN
  output logic                           err_long,
  output logic [7:0]                     err_cnt
`else
  output logic                           err_long
`endif
);

  localparam int IDX_W = $clog2(NUM_CELLS);
  localparam int VEC_W = NUM_CELLS * IN_BITS;
  localparam logic [SAMPLE_W-1:0] CODE_MAX = SAMPLE_W'((1 << IN_BITS) - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_CELLS - 1);

  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [VEC_W-1:0]      fill_q;
  logic                  hold_q;      // completed frame parked in fill_q
  logic [VEC_W-1:0]      out_q;
  logic                  m_valid_q;
  logic                  err_short_q;
  logic                  err_long_q;

  logic [SAMPLE_W-1:0]   q_shift;
  logic [IN_BITS-1:0]    code;
  logic [VEC_W-1:0]      fill_d;
  logic                  accept;
  logic                  out_free;
  logic                  at_last;
  logic                  in_fill;
  logic                  frame_done;
  logic                  short_ev;
  logic                  long_ev;

  // Quantizer: shift, then clamp to the largest code.
  always_comb begin
    q_shift = s_data >> Q_SHIFT;
    if (q_shift > CODE_MAX) begin
      code = CODE_MAX[IN_BITS-1:0];
    end else begin
      code = q_shift[IN_BITS-1:0];
    end
  end

  // Fill vector with the current code dropped into slot idx_q. This is also
  // the complete frame when idx_q is the last cell, so it can be loaded into
  // the output register on the same edge.
  always_comb begin
    fill_d = fill_q;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx_q == i[IDX_W-1:0]) begin
        fill_d[i*IN_BITS +: IN_BITS] = code;
      end
    end
  end

  // DISCARD always accepts. A parked frame only stalls FILL.
  assign s_ready    = (state_q == ST_DISCARD) || !hold_q;
  assign accept     = s_valid && s_ready;
  assign out_free   = !m_valid_q || m_ready;
  assign at_last    = (idx_q == LAST_IDX);
  assign in_fill    = (state_q == ST_FILL);
  assign frame_done = accept && in_fill && at_last;
  assign short_ev   = accept && in_fill && !at_last && s_last;
  assign long_ev    = frame_done && !s_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      fill_q      <= '0;
      hold_q      <= 1'b0;
      out_q       <= '0;
      m_valid_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      err_short_q <= short_ev;
      err_long_q  <= long_ev;

      // Output side. A parked frame and a newly completed frame never
      // compete: while hold_q is set, FILL is not accepting.
      if (hold_q && out_free) begin
        out_q     <= fill_q;
        m_valid_q <= 1'b1;
        hold_q    <= 1'b0;
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end

      if (accept) begin
        case (state_q)
          ST_FILL: begin
            fill_q <= fill_d;
            if (at_last) begin
              idx_q <= '0;
              if (out_free) begin
                out_q     <= fill_d;
                m_valid_q <= 1'b1;
              end else begin
                hold_q <= 1'b1;
              end
              if (!s_last) begin
                state_q <= ST_DISCARD;
              end
            end else if (s_last) begin
              idx_q <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          ST_DISCARD: begin
            if (s_last) begin
              state_q <= ST_FILL;
            end
          end
          default: state_q <= ST_FILL;
        endcase
      end
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = out_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

`ifdef HGCAL_PACK_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counts on the same edge that raises the pulse, so err_cnt and the pulse
  // become visible together. The two events are mutually exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if ((short_ev || long_ev) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hgcal_input_packer.sv
module tb_hgcal_input_packer;

  localparam int N  = 48;
  localparam int VW = N * 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [15:0]   s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [VW-1:0] m_data;
  logic          err_short;
  logic          err_long;
`ifdef HGCAL_PACK_ERRCNT_EN
  logic [7:0]    err_cnt;
`endif

  hgcal_input_packer #(
    .NUM_CELLS(N), .SAMPLE_W(16), .IN_BITS(2), .Q_SHIFT(10)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_short(err_short),
`ifdef HGCAL_PACK_ERRCNT_EN
    .err_long(err_long),
    .err_cnt(err_cnt)
`else
    .err_long(err_long)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frames assembled from accepted samples by the framing
  // rules, codes by plain arithmetic.
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] obs_q[$];
  logic [15:0]   cur[$];
  bit            discarding = 0;
  int            exp_short = 0, exp_long = 0, obs_short = 0, obs_long = 0;
  int            exp_cnt = 0;
  bit            rnd_rdy = 0;

  function automatic logic [1:0] qcode(input logic [15:0] s);
    int q;
    q = int'(s) / 1024;
    return (q > 3) ? 2'd3 : 2'(q);
  endfunction

  function automatic logic [VW-1:0] pack(input logic [15:0] f[$]);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*2 +: 2] = qcode(f[i]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      cur.delete();
      discarding = 0;
      exp_q.delete();
      obs_q.delete();
      exp_cnt = 0;
    end else begin
      if (m_valid && m_ready) obs_q.push_back(m_data);
      if (err_short) obs_short++;
      if (err_long)  obs_long++;
      if (s_valid && s_ready) begin
        if (discarding) begin
          if (s_last) discarding = 0;
        end else begin
          cur.push_back(s_data);
          if (cur.size() == N) begin
            exp_q.push_back(pack(cur));
            cur.delete();
            if (!s_last) begin
              exp_long++;
              if (exp_cnt < 255) exp_cnt++;
              discarding = 1;
            end
          end else if (s_last) begin
            exp_short++;
            if (exp_cnt < 255) exp_cnt++;
            cur.delete();
          end
        end
      end
    end
  end

  task automatic chkv(input string tag, input logic [VW-1:0] o, input logic [VW-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chki(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Presents one sample and returns 1 time unit after the edge that took it.
  task automatic send_beat(input logic [15:0] d, input logic l);
    bit acc;
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    acc = 0;
    n = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
      if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) chk1("beat_timeout", 1'b0, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] f[$]);
    foreach (f[i]) send_beat(f[i], (i == f.size() - 1));
  endtask

  task automatic check_frames(input string tag);
    chki({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chkv({tag, "_frame"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [15:0] rnd_sample();
    logic [15:0] r;
    r = 16'($urandom);
    return r >> $urandom_range(0, 6);
  endfunction

  initial begin
    logic [15:0]   f[$];
    logic [15:0]   fa[$];
    logic [15:0]   fb[$];
    logic [VW-1:0] v;
    int            len;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk1("rst_m_valid", m_valid, 1'b0);
    chkv("rst_m_data", m_data, '0);
    chk1("rst_err_short", err_short, 1'b0);
    chk1("rst_err_long", err_long, 1'b0);
    chk1("rst_s_ready", s_ready, 1'b1);
`ifdef HGCAL_PACK_ERRCNT_EN
    chki("rst_err_cnt", int'(err_cnt), 0);
`endif

    // Nominal frame, codes 0,1,2,3 repeating.
    f.delete();
    for (int i = 0; i < N; i++) f.push_back(16'((i % 4) * 16'h0400));
    v = '0;
    for (int i = 0; i < N; i++) v[i*2 +: 2] = 2'(i % 4);
    send_frame(f);
    chk1("nom_latency_valid", m_valid, 1'b1);
    chkv("nom_data", m_data, v);
    idle(3);
    chk1("nom_valid_drops", m_valid, 1'b0);
    check_frames("nom");
    chki("nom_no_short", obs_short, 0);
    chki("nom_no_long", obs_long, 0);

    // Saturation and just-below-threshold.
    f.delete();
    for (int i = 0; i < N; i++) f.push_back(16'hFFFF);
    send_frame(f);
    chkv("sat_all_ones", m_data, {VW{1'b1}});
    f.delete();
    for (int i = 0; i < N; i++) f.push_back(16'h03FF);
    send_frame(f);
    chkv("below_thresh_zero", m_data, '0);
    f.delete();
    for (int i = 0; i < N; i++) f.push_back((i % 2 == 0) ? 16'h07FF : 16'h0C00);
    send_frame(f);
    idle(3);
    check_frames("sat");

    // Backpressure: two frames with m_ready low.
    m_ready = 1'b0;
    fa.delete(); fb.delete();
    for (int i = 0; i < N; i++) begin
      fa.push_back(rnd_sample());
      fb.push_back(rnd_sample());
    end
    send_frame(fa);
    send_frame(fb);
    chk1("bp_valid", m_valid, 1'b1);
    chkv("bp_first_held", m_data, pack(fa));
    chk1("bp_s_ready_low", s_ready, 1'b0);
    idle(4);
    chkv("bp_first_stable", m_data, pack(fa));
    chk1("bp_s_ready_still_low", s_ready, 1'b0);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    chkv("bp_second_loaded", m_data, pack(fb));
    chk1("bp_second_valid", m_valid, 1'b1);
    chk1("bp_s_ready_back", s_ready, 1'b1);
    m_ready = 1'b1;
    f.delete();
    for (int i = 0; i < N; i++) f.push_back(rnd_sample());
    send_frame(f);
    idle(3);
    check_frames("bp");

    // Short frame.
    f.delete();
    for (int i = 0; i < 10; i++) f.push_back(rnd_sample());
    send_frame(f);
    chk1("short_pulse", err_short, 1'b1);
    chk1("short_no_valid", m_valid, 1'b0);
    idle(1);
    chk1("short_pulse_ends", err_short, 1'b0);
    f.delete();
    for (int i = 0; i < N; i++) f.push_back(rnd_sample());
    send_frame(f);
    idle(3);
    check_frames("short");
    chki("short_count", obs_short, exp_short);

    // Long frame: 52 beats.
    for (int i = 0; i < 52; i++) begin
      send_beat(rnd_sample(), (i == 51));
      if (i == 47) chk1("long_pulse", err_long, 1'b1);
      if (i == 48) chk1("long_pulse_ends", err_long, 1'b0);
    end
    f.delete();
    for (int i = 0; i < N; i++) f.push_back(rnd_sample());
    send_frame(f);
    idle(3);
    check_frames("long");
    chki("long_count", obs_long, exp_long);

    // Randomized frames with random lengths and random backpressure.
    rnd_rdy = 1;
    for (int k = 0; k < 16; k++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 56)) : N;
      for (int i = 0; i < len; i++) send_beat(rnd_sample(), (i == len - 1));
    end
    rnd_rdy = 0;
    m_ready = 1'b1;
    idle(5);
    check_frames("rand");
    chki("rand_short_count", obs_short, exp_short);
    chki("rand_long_count", obs_long, exp_long);
`ifdef HGCAL_PACK_ERRCNT_EN
    chki("rand_err_cnt", int'(err_cnt), exp_cnt);
`endif

    // Reset mid-frame with a frame buffered at the output.
    m_ready = 1'b0;
    f.delete();
    for (int i = 0; i < N; i++) f.push_back(rnd_sample());
    send_frame(f);
    for (int i = 0; i < 20; i++) send_beat(rnd_sample(), 1'b0);
    chki("pre_rst_buffered", exp_q.size() - obs_q.size(), 1);
    chk1("pre_rst_valid", m_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst_valid", m_valid, 1'b0);
    chkv("async_rst_data", m_data, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk1("post_rst_s_ready", s_ready, 1'b1);
    m_ready = 1'b1;
    f.delete();
    for (int i = 0; i < N; i++) f.push_back(rnd_sample());
    send_frame(f);
    chkv("post_rst_frame", m_data, pack(f));
    idle(3);
    check_frames("post_rst");
`ifdef HGCAL_PACK_ERRCNT_EN
    chki("post_rst_err_cnt", int'(err_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
